led_pattern_sequencer: RTL

Parametrised LED pattern generator driving an N-bit LED bank from a single system clock. It is the successor to the fixed 8-LED left-rotating running light. It adds configurable LED count, runtime speed selection, four display modes (rotate left, rotate right, bounce, fill/drain), pause and synchronous restart, and a step strobe for downstream logic such as buzzers or segment displays. It sits directly between the board clock/reset and the LED pins.

---
 rtl/led_pattern_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// Purpose: N-bit LED pattern generator (rotate L/R, bounce, fill/drain) with runtime speed.
// Latency: a step updates led and step_tick together, limit enabled clk cycles after the previous one.
// Backpressure: none; en=0 freezes prescaler, pattern and FSM, restart/mode change reload the initial state.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   en                 1 = run, 0 = pause
//   restart            one-cycle synchronous restart of the current mode
//   mode[1:0]          0 rotate-left, 1 rotate-right, 2 bounce, 3 fill/drain
//   speed[1:0]         step period = max(1, DIV_FACTOR >> speed) cycles
//   led[N_LED-1:0]     LED drive (inverted when ACTIVE_LOW)
//   step_tick          registered pulse, high while a freshly stepped pattern first shows
module led_pattern_sequencer #(
    parameter int N_LED      = 8,
    parameter int DIV_FACTOR = 1200000,
    parameter int CNT_W      = 24,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] led,
    output logic             step_tick
);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [CNT_W-1:0] DIV_W = CNT_W'(DIV_FACTOR);
    localparam logic [N_LED-1:0] PAT_INIT = N_LED'(1);

    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] pat_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dir;        // 0 = moving up, 1 = moving down (bounce)
    logic             dir_nxt;
    logic [0:0]       phase;
    logic [0:0]       phase_nxt;
    logic [1:0]       mode_q;

    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] limit;
    logic             tick;
    logic             do_restart;

    // Step period; very fast speeds clamp at one cycle per step.
    assign shifted = DIV_W >> speed;
    assign limit   = (shifted == '0) ? CNT_W'(1) : shifted;

    // >= rather than == so that shortening the period mid-count ticks at once
    // instead of wrapping through the whole counter range.
    assign tick       = en && (cnt >= limit - CNT_W'(1));
    assign do_restart = restart || (mode != mode_q);

    always_comb begin
        pat_nxt   = pat;
        dir_nxt   = dir;
        phase_nxt = phase;
        case (mode_q)
            2'd0: pat_nxt = {pat[N_LED-2:0], pat[N_LED-1]};
            2'd1: pat_nxt = {pat[0], pat[N_LED-1:1]};
            2'd2: begin
                // Turn and move in the same step so the end LEDs get no dwell.
                if (!dir) begin
                    if (pat[N_LED-1]) begin
                        dir_nxt = 1'b1;
                        pat_nxt = pat >> 1;
                    end else begin
                        pat_nxt = pat << 1;
                    end
                end else begin
                    if (pat[0]) begin
                        dir_nxt = 1'b0;
                        pat_nxt = pat << 1;
                    end else begin
                        pat_nxt = pat >> 1;
                    end
                end
            end
            default: begin
                if (phase == FILL) begin
                    pat_nxt = {pat[N_LED-2:0], 1'b1};
                    if (&pat_nxt) phase_nxt = DRAIN;
                end else begin
                    pat_nxt = {pat[N_LED-2:0], 1'b0};
                    if (pat_nxt == '0) phase_nxt = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat       <= PAT_INIT;
            cnt       <= '0;
            dir       <= 1'b0;
            phase     <= FILL;
            step_tick <= 1'b0;
            mode_q    <= mode;
        end else if (do_restart) begin
            pat       <= PAT_INIT;
            cnt       <= '0;
            dir       <= 1'b0;
            phase     <= FILL;
            step_tick <= 1'b0;
            mode_q    <= mode;
        end else if (!en) begin
            step_tick <= 1'b0;
        end else begin
            step_tick <= tick;
            if (tick) begin
                cnt   <= '0;
                pat   <= pat_nxt;
                dir   <= dir_nxt;
                phase <= phase_nxt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign led = (ACTIVE_LOW != 0) ? ~pat : pat;

endmodule
